// File: rtl/cafe_dispense_sequencer.sv
// Recipe sequencer for the coffee machine: accepts one paid drink request and
// steps through the ingredient valves one at a time for recipe-defined durations.
module cafe_dispense_sequencer #(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned DONE_UNITS = 2
) (
  input  logic       clk_50Mhz,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] sel,
  input  logic       sugar,
  input  logic       pay_ok,
  input  logic       abort,
  output logic       consume,
  output logic       busy,
  output logic       agua,
  output logic       cafe,
  output logic       leche,
  output logic       choco,
  output logic       azucar,
  output logic       bebidaLista,
  output logic [2:0] step
);

  localparam int unsigned     PresW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PresW-1:0] PresLast = PresW'(TICK_DIV - 1);
  localparam logic [2:0]      DoneUnits = 3'(DONE_UNITS);

  // Encoding doubles as the display step code.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StCafe   = 3'd1,
    StAgua   = 3'd2,
    StLeche  = 3'd3,
    StChoco  = 3'd4,
    StAzucar = 3'd5,
    StDone   = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [PresW-1:0] presc_q, presc_d;
  logic [2:0]       units_q, units_d;
  logic [1:0]       sel_q, sel_d;
  logic             sugar_q, sugar_d;
  logic             consume_q, consume_d;

  logic             unit_done;
  logic             step_last;

  // Duration of a given step in time units for the latched recipe.
  function automatic logic [2:0] step_units(state_e s, logic [1:0] sl, logic sg);
    logic [2:0] u;
    u = 3'd0;
    case (s)
      StCafe:   u = 3'd3;
      StAgua:   u = (sl == 2'b00) ? 3'd2 : (sl == 2'b11) ? 3'd6 : 3'd0;
      StLeche:  u = (sl == 2'b01) ? 3'd4 : (sl == 2'b10) ? 3'd3 : 3'd0;
      StChoco:  u = (sl == 2'b10) ? 3'd2 : 3'd0;
      StAzucar: u = sg ? 3'd1 : 3'd0;
      StDone:   u = DoneUnits;
      default:  u = 3'd0;
    endcase
    return u;
  endfunction

  // First nonzero step after s; later assignments override, so the earliest wins.
  function automatic state_e next_step(state_e s, logic [1:0] sl, logic sg);
    state_e n;
    n = StDone;
    if ((s inside {StCafe, StAgua, StLeche, StChoco}) && (step_units(StAzucar, sl, sg) != 3'd0))
      n = StAzucar;
    if ((s inside {StCafe, StAgua, StLeche}) && (step_units(StChoco, sl, sg) != 3'd0))
      n = StChoco;
    if ((s inside {StCafe, StAgua}) && (step_units(StLeche, sl, sg) != 3'd0))
      n = StLeche;
    if ((s == StCafe) && (step_units(StAgua, sl, sg) != 3'd0))
      n = StAgua;
    return n;
  endfunction

  // Next-state: acceptance, abort, step timing and counter clearing on entry.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    units_d   = units_q;
    sel_d     = sel_q;
    sugar_d   = sugar_q;
    consume_d = 1'b0;
    unit_done = (presc_q == PresLast);
    step_last = unit_done && (units_q == (step_units(state_q, sel_q, sugar_q) - 3'd1));

    if (state_q == StIdle) begin
      presc_d = '0;
      units_d = 3'd0;
      if (start && pay_ok) begin
        state_d   = StCafe;
        sel_d     = sel;
        sugar_d   = sugar;
        consume_d = 1'b1;
      end
    end else if (abort) begin
      state_d = StIdle;
      presc_d = '0;
      units_d = 3'd0;
    end else if (step_last) begin
      state_d = (state_q == StDone) ? StIdle : next_step(state_q, sel_q, sugar_q);
      presc_d = '0;
      units_d = 3'd0;
    end else if (unit_done) begin
      presc_d = '0;
      units_d = units_q + 3'd1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // State, counters and latched request.
  always_ff @(posedge clk_50Mhz or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      units_q   <= 3'd0;
      sel_q     <= 2'b00;
      sugar_q   <= 1'b0;
      consume_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      units_q   <= units_d;
      sel_q     <= sel_d;
      sugar_q   <= sugar_d;
      consume_q <= consume_d;
    end
  end

  // Outputs decoded from the state register only.
  always_comb begin
    cafe        = 1'b0;
    agua        = 1'b0;
    leche       = 1'b0;
    choco       = 1'b0;
    azucar      = 1'b0;
    bebidaLista = 1'b0;
    busy        = (state_q != StIdle);
    step        = state_q;
    consume     = consume_q;
    unique case (state_q)
      StCafe:   cafe        = 1'b1;
      StAgua:   agua        = 1'b1;
      StLeche:  leche       = 1'b1;
      StChoco:  choco       = 1'b1;
      StAzucar: azucar      = 1'b1;
      StDone:   bebidaLista = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_cafe_dispense_sequencer.sv
// Bench for cafe_dispense_sequencer: recipe table, hand-written corner cases and
// randomized traffic checked every cycle against a queue-based recipe model.
module tb_cafe_dispense_sequencer;

  localparam int unsigned Tick  = 4;
  localparam int unsigned DoneU = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] sel = 2'b00;
  logic       sugar = 1'b0;
  logic       pay_ok = 1'b0;
  logic       abort = 1'b0;
  logic       consume, busy, agua, cafe, leche, choco, azucar, bebidaLista;
  logic [2:0] step;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  cafe_dispense_sequencer #(
    .TICK_DIV  (Tick),
    .DONE_UNITS(DoneU)
  ) dut (
    .clk_50Mhz  (clk),
    .rst        (rst),
    .start      (start),
    .sel        (sel),
    .sugar      (sugar),
    .pay_ok     (pay_ok),
    .abort      (abort),
    .consume    (consume),
    .busy       (busy),
    .agua       (agua),
    .cafe       (cafe),
    .leche      (leche),
    .choco      (choco),
    .azucar     (azucar),
    .bebidaLista(bebidaLista),
    .step       (step)
  );

  always #5 clk = ~clk;

  // Recipe units per drink in order cafe, agua, leche, choco.
  int rcp[4][4] = '{'{3, 2, 0, 0}, '{3, 0, 4, 0}, '{3, 0, 3, 2}, '{3, 6, 0, 0}};

  // Reference model: queue of step codes for the upcoming cycles of the drink.
  int q[$];
  bit exp_cons = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      exp_cons = 1'b0;
    end else begin
      exp_cons = 1'b0;
      if (q.size() != 0) begin
        if (abort) q.delete();
        else void'(q.pop_front());
      end else if (start && pay_ok) begin
        for (int k = 0; k < 4; k++) repeat (rcp[sel][k] * Tick) q.push_back(k + 1);
        if (sugar) repeat (Tick) q.push_back(5);
        repeat (DoneU * Tick) q.push_back(6);
        exp_cons = 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      int st;
      logic [10:0] expv, actv;
      st   = (q.size() != 0) ? q[0] : 0;
      expv = {exp_cons, st != 0, st == 6, st == 5, st == 4, st == 3, st == 2, st == 1, 3'(st)};
      actv = {consume, busy, bebidaLista, azucar, choco, leche, agua, cafe, step};
      nvec++;
      if (actv !== expv) begin
        nerr++;
        $display("FAIL model_cycle t=%0t: got %b expected %b", $time, actv, expv);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] sel;
    logic       sugar;
    bit         disturb;
    int         abort_at;
    int         n_cafe, n_agua, n_leche, n_choco, n_azucar, n_done, n_busy, n_cons;
    int         seq;
  } vec_t;

  vec_t tbl[7];

  task automatic run_row(input vec_t v, input int idx);
    int nc, na, nl, nch, naz, nd, nb, ncs, ovl, seq;
    logic [2:0] last;
    bit ended;
    nc = 0; na = 0; nl = 0; nch = 0; naz = 0; nd = 0; nb = 0; ncs = 0; ovl = 0;
    seq = 0; last = 3'd0; ended = 1'b0;
    @(negedge clk);
    sel = v.sel; sugar = v.sugar; pay_ok = 1'b1; start = 1'b1; abort = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (step !== last) begin
        seq  = (seq << 4) | int'(step);
        last = step;
      end
      nc += int'(cafe); na += int'(agua); nl += int'(leche); nch += int'(choco);
      naz += int'(azucar); nd += int'(bebidaLista); nb += int'(busy); ncs += int'(consume);
      if ((int'(cafe) + int'(agua) + int'(leche) + int'(choco) + int'(azucar)) > 1) ovl++;
      if (!busy) begin
        ended = 1'b1;
        break;
      end
      if (v.disturb) begin
        if (i == 0) begin
          sel = 2'b11; sugar = 1'b1;
        end
        start = (i == 4);
      end
      abort = (i == v.abort_at);
      @(negedge clk);
    end
    abort = 1'b0; start = 1'b0;
    check($sformatf("row%0d_ended", idx), 32'(ended), 32'd1);
    check($sformatf("row%0d_cafe", idx), nc, v.n_cafe);
    check($sformatf("row%0d_agua", idx), na, v.n_agua);
    check($sformatf("row%0d_leche", idx), nl, v.n_leche);
    check($sformatf("row%0d_choco", idx), nch, v.n_choco);
    check($sformatf("row%0d_azucar", idx), naz, v.n_azucar);
    check($sformatf("row%0d_done", idx), nd, v.n_done);
    check($sformatf("row%0d_busy", idx), nb, v.n_busy);
    check($sformatf("row%0d_consume", idx), ncs, v.n_cons);
    check($sformatf("row%0d_overlap", idx), ovl, 0);
    check($sformatf("row%0d_stepseq", idx), seq, v.seq);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  initial begin
    bit any;
    //               sel    sug  dist abort cafe agua leche choco azu done busy cons seq
    tbl[0] = '{2'b00, 1'b0, 0, -1, 12, 8,  0,  0, 0, 8, 28, 1, 'h1260};
    tbl[1] = '{2'b01, 1'b0, 1, -1, 12, 0,  16, 0, 0, 8, 36, 1, 'h1360};
    tbl[2] = '{2'b10, 1'b1, 0, -1, 12, 0,  12, 8, 4, 8, 44, 1, 'h134560};
    tbl[3] = '{2'b01, 1'b0, 0, 14, 12, 0,  3,  0, 0, 0, 15, 1, 'h130};
    tbl[4] = '{2'b11, 1'b0, 0, -1, 12, 24, 0,  0, 0, 8, 44, 1, 'h1260};
    tbl[5] = '{2'b00, 1'b1, 0, -1, 12, 8,  0,  0, 4, 8, 32, 1, 'h12560};
    tbl[6] = '{2'b01, 1'b0, 0, -1, 12, 0,  16, 0, 0, 8, 36, 1, 'h1360};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({consume, busy, bebidaLista, azucar, choco, leche, agua, cafe, step}), 32'd0);
    rst = 1'b1;
    chk_en = 1'b1;

    // Recipe table, including latched-request and abort rows.
    for (int r = 0; r < 7; r++) run_row(tbl[r], r);

    // start without payment is ignored; raising pay_ok accepts on that edge.
    @(negedge clk);
    sel = 2'b00; sugar = 1'b0; start = 1'b1; pay_ok = 1'b0;
    any = 1'b0;
    repeat (20) begin
      @(negedge clk);
      any |= consume | busy | (step != 3'd0);
    end
    check("nopay_idle", 32'(any), 32'd0);
    pay_ok = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("nopay_accept_consume", 32'(consume), 32'd1);
    check("nopay_accept_step", 32'(step), 32'd1);
    wait_idle("nopay_drain");

    // Asynchronous reset in the middle of the americano agua step.
    @(negedge clk);
    sel = 2'b11; sugar = 1'b0; start = 1'b1; pay_ok = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    check("pre_rst_agua", 32'(agua), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("async_rst_agua", 32'(agua), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_step", 32'(step), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    any = 1'b0;
    repeat (10) begin
      @(negedge clk);
      any |= busy | consume;
    end
    check("post_rst_idle", 32'(any), 32'd0);

    // Randomized traffic; the per-cycle model check covers it.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start  = ($urandom_range(0, 3) == 0);
      sel    = 2'($urandom_range(0, 3));
      sugar  = 1'($urandom_range(0, 1));
      pay_ok = ($urandom_range(0, 3) != 0);
      abort  = ($urandom_range(0, 59) == 0);
    end
    start = 1'b0; abort = 1'b0;
    wait_idle("random_drain");

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cafe_dispense_sequencer.md
# cafe_dispense_sequencer

Recipe sequencer for the coffee machine datapath. After the coin/credit logic reports sufficient payment, it accepts one drink request and drives the ingredient valves (cafe, agua, leche, choco, azucar) one at a time for fixed, recipe-defined durations. It then raises bebidaLista. It sits between the selection/credit FSM and the valve outputs, and it exports a step code for the hex display.

## Interface
- TICK_DIV, default 50_000_000: clk_50Mhz cycles per time unit (1 s at 50 MHz); must be ≥ 2.
- DONE_UNITS, default 2: time units that bebidaLista stays high.
- clk_50Mhz  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous and active-low.
- start  input  1  drink request, level-sampled in IDLE.
- sel  input  2  drink select: 00 espresso, 01 latte, 10 mocha, 11 americano.
- sugar  input  1  add azucar step; sampled with start.
- pay_ok  input  1  credit sufficient; gates acceptance.
- abort  input  1  cancel the current drink.
- consume  output  1  one-cycle pulse on acceptance; the credit FSM deducts the price.
- busy  output  1  high in every state except IDLE.
- agua, cafe, leche, choco, azucar  output  1 each  valve enables; at most one high at a time.
- bebidaLista  output  1  high during DONE.
- step  output  3  state code for the hex display: 0 IDLE, 1 CAFE, 2 AGUA, 3 LECHE, 4 CHOCO, 5 AZUCAR, 6 DONE.

## Operation
- States: IDLE, CAFE, AGUA, LECHE, CHOCO, AZUCAR, DONE. Fixed order. Steps with 0 units are skipped.
- Recipe units (cafe/agua/leche/choco):
  - espresso: 3/2/0/0
  - latte: 3/0/4/0
  - mocha: 3/0/3/2
  - americano: 3/6/0/0
  - azucar: 1 unit if the latched sugar bit is 1, else 0.
- Acceptance: in IDLE with start=1 and pay_ok=1, latch sel and sugar, pulse consume, and go to CAFE.
  - start with pay_ok=0 is ignored; consume stays 0 and the block stays in IDLE.
- start, sel and sugar are ignored while busy. Latched values never change mid-drink.
- Each step lasts units×TICK_DIV cycles. The prescaler and unit counter clear on every state entry.
- After the last nonzero step: DONE for DONE_UNITS×TICK_DIV cycles, then IDLE.
- Outputs (valves, busy, bebidaLista, step) are decoded from the state register.
- abort=1 in any state other than IDLE: next state IDLE.
  - All valves drop on the next edge; DONE is not entered; bebidaLista stays 0.
  - No refund logic here; consume has already fired.
  - abort in IDLE has no effect. If abort and start are both high in IDLE, start is evaluated normally.
- Reset (rst=0): state goes to IDLE immediately, counters clear, and all outputs go to 0 (step=0), regardless of state.
- Counter widths: prescaler is $clog2(TICK_DIV) bits. Unit counter is 3 bits (maximum 6 units); no overflow is possible.

## Timing
- Acceptance edge E (start=1, pay_ok=1 sampled):
  - consume is high for exactly the cycle after E.
  - State is CAFE from E, so cafe=1 and busy=1 in the same cycle as consume.
- Step transition: the previous valve falls and the next valve rises on the same edge. There is no gap and no overlap.
- Latency from acceptance to bebidaLista = sum(units)×TICK_DIV cycles.
- DONE→IDLE: a new start can be accepted on the first IDLE cycle.
- abort: sampled on edge A; outputs are 0 and step=0 from the cycle after A.
- Reset release: first active edge samples IDLE inputs normally.

## Test plan
All scenarios use TICK_DIV=4 and DONE_UNITS=2.
1. Espresso, sugar=0, pay_ok=1, start pulse → consume 1 cycle; then cafe 12 cycles, agua 8 cycles, bebidaLista 8 cycles; busy high 28 cycles; step sequence 1,2,6,0.
2. Mocha, sugar=1 → cafe 12, leche 12, choco 8, azucar 4, bebidaLista 8 cycles; never two valves high together; agua stays 0.
3. start=1 with pay_ok=0 for 20 cycles → consume=0, busy=0, step=0. Raising pay_ok while start=1 → accepted on that edge.
4. Latte accepted, then sel=11 and sugar=1 driven, and start pulsed at cycle 5 → recipe stays latte (cafe 12, leche 16, no azucar); no second consume.
5. Latte with abort=1 at cycle 15 (in LECHE) → leche drops the next cycle, busy=0, bebidaLista never asserts; a new start is then accepted.
6. Americano: drive rst=0 during AGUA between clock edges → agua, busy and step go to 0 immediately without waiting for a clock edge. After release, idle until the next start.
